// File: rtl/fp32_pkg.sv
// Shared binary32 field layout, constants and enums for the FP divider.
package fp32_pkg;
  localparam int SIGN_W    = 1;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int BIAS      = 127;
  localparam int QUOT_BITS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, UNPACK, ITER, ROUND} state_t;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_t;

  // Denormals classify as ZERO (flush-to-zero on input).
  function automatic fclass_t classify(input logic [31:0] x);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    e = x[30:23];
    m = x[22:0];
    if (e == '0)        return ZERO;
    else if (e == '1)   return (m == '0) ? INF : NAN;
    else                return NORM;
  endfunction
endpackage

// File: rtl/fp_div_mant_core.sv
// Iterative restoring mantissa divider: ITER_BITS quotient bits per cycle, 26 bits total.
module fp_div_mant_core
  import fp32_pkg::*;
#(
  parameter int ITER_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic [25:0] quot,
  output logic        sticky,
  output logic        done
);
  localparam int CYCLES = QUOT_BITS / ITER_BITS;

  logic [24:0] rem, rem_nxt;
  logic [23:0] dvs;
  logic [25:0] quot_nxt;
  logic [4:0]  cnt;

  // Remainder stays below the divisor after each step, so the shift never overflows 25 bits.
  always_comb begin
    rem_nxt  = rem;
    quot_nxt = quot;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (rem_nxt >= {1'b0, dvs}) begin
        rem_nxt  = rem_nxt - {1'b0, dvs};
        quot_nxt = {quot_nxt[24:0], 1'b1};
      end else begin
        quot_nxt = {quot_nxt[24:0], 1'b0};
      end
      rem_nxt = {rem_nxt[23:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dvs  <= '0;
      quot <= '0;
      cnt  <= '0;
    end else if (start) begin
      rem  <= {1'b0, dividend};
      dvs  <= divisor;
      quot <= '0;
      cnt  <= 5'(CYCLES);
    end else if (cnt != '0) begin
      rem  <= rem_nxt;
      quot <= quot_nxt;
      cnt  <= cnt - 5'd1;
    end
  end

  assign sticky = |rem;
  // High during the final iteration so the caller can advance on the same edge.
  assign done   = (cnt == 5'd1);
endmodule

// File: rtl/fp_mult.sv
// Multi-cycle binary32 divider C = A / B (name kept for existing instantiations).
module fp_mult
  import fp32_pkg::*;
#(
  parameter int ITER_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] C,
  output logic        ready
);
  state_t             state;
  logic               req_tog, ack_tog, pending;
  logic [31:0]        a_q, b_q;
  logic               sign_q, special_q;
  logic [31:0]        spec_res_q;
  logic signed [9:0]  exp_q;

  fclass_t            ca, cb;
  logic               sign_now, spec_now;
  logic signed [9:0]  exp_now;
  logic [31:0]        spec_res;

  logic               core_start, core_done, sticky;
  logic [25:0]        quot;

  logic               norm, g, r, inc;
  logic [22:0]        frac;
  logic signed [9:0]  e1, e2;
  logic [32:0]        ext;
  logic [31:0]        round_res;

  // Toggle on start's rising edge so sub-cycle pulses survive until the next clk edge.
  always_ff @(posedge start or negedge rst_n) begin
    if (!rst_n) req_tog <= 1'b0;
    else        req_tog <= ~req_tog;
  end

  assign pending = req_tog ^ ack_tog;

  always_comb begin
    ca       = classify(a_q);
    cb       = classify(b_q);
    sign_now = a_q[31] ^ b_q[31];
    exp_now  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
    spec_now = !(ca == NORM && cb == NORM);
    if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
      spec_res = QNAN;
    else if (ca == INF || cb == ZERO)
      spec_res = {sign_now, POS_INF[30:0]};
    else
      spec_res = {sign_now, 31'd0};
  end

  assign core_start = (state == UNPACK) && !spec_now;

  fp_div_mant_core #(.ITER_BITS(ITER_BITS)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .dividend ({1'b1, a_q[22:0]}),
    .divisor  ({1'b1, b_q[22:0]}),
    .quot     (quot),
    .sticky   (sticky),
    .done     (core_done)
  );

  // Adding the round increment to {exp, frac} lets a mantissa carry bump the exponent.
  always_comb begin
    norm = quot[25];
    frac = norm ? quot[24:2] : quot[23:1];
    g    = norm ? quot[1] : quot[0];
    r    = norm ? quot[0] : 1'b0;
    e1   = norm ? exp_q : exp_q - 10'sd1;
    inc  = g & (r | sticky | frac[0]);
    ext  = {e1, frac} + {32'd0, inc};
    e2   = $signed(ext[32:23]);
    if (e2 >= 10'sd255)    round_res = {sign_q, POS_INF[30:0]};
    else if (e2 <= 10'sd0) round_res = {sign_q, 31'd0};
    else                   round_res = {sign_q, e2[7:0], ext[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_tog    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      C          <= '0;
      ready      <= 1'b0;
    end else begin
      // Always re-sync: accepts a pending request in IDLE, discards starts while busy.
      ack_tog <= req_tog;
      case (state)
        IDLE: if (pending) begin
          a_q   <= A;
          b_q   <= B;
          ready <= 1'b0;
          state <= UNPACK;
        end
        UNPACK: begin
          sign_q     <= sign_now;
          exp_q      <= exp_now;
          special_q  <= spec_now;
          spec_res_q <= spec_res;
          state      <= spec_now ? ROUND : ITER;
        end
        ITER: if (core_done) state <= ROUND;
        ROUND: begin
          C     <= special_q ? spec_res_q : round_res;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mult.sv
// Self-checking bench for fp_mult (binary32 divider): directed table, corner sequences, random vs model.
module tb_fp_mult;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] C;
  logic        ready;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Q_NAN = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  fp_mult #(.ITER_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exact quotient via wide integer division, then round-to-nearest-even on the discarded bits.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e, sh;
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    longint unsigned ma, mb, num, q, rm, mant, low, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return Q_NAN;
    if (a_inf || b_zero) return {s, 8'hFF, 23'h0};
    if (a_zero || b_inf) return {s, 31'h0};
    ma  = 64'(a[22:0]) | 64'h80_0000;
    mb  = 64'(b[22:0]) | 64'h80_0000;
    num = ma << 40;
    q   = num / mb;
    rm  = num % mb;
    e   = ea - eb + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    mant = q >> sh;
    low  = q & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    up   = (low > half) || (low == half && (rm != 0 || mant[0]));
    mant = mant + 64'(up);
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    int          sel;
    x   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel >= 5 && sel <= 8) x[30:23] = 8'($urandom_range(100, 154));
    else if (sel == 9) begin
      case ($urandom_range(0, 5))
        0: x = 32'h0000_0000;
        1: x = 32'h8000_0000;
        2: x = 32'h7F80_0000;
        3: x = 32'hFF80_0000;
        4: x = 32'h7FA0_0001;
        default: x = 32'h0000_0001;
      endcase
    end
    return x;
  endfunction

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    #2 start = 1'b1;
    #1 start = 1'b0;
  endtask

  // lat = edges from pulse until ready; 0 if the start was never accepted, -1 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    pulse_start(a, b);
    lat = -1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        A = $urandom;
        B = $urandom;
        if (ready) begin
          lat = 0;
          break;
        end
      end else if (ready) begin
        lat = n;
        break;
      end
    end
    res = C;
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] res, exp;
    int          lat, bad_lat, dropped;

    vecs[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000};
    vecs[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB};
    vecs[2] = '{32'hC100_0000, 32'h3F00_0000, 32'hC180_0000};
    vecs[3] = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000};
    vecs[5] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000};
    vecs[6] = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000};
    vecs[7] = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000};

    #1;
    chk("reset_c", C, 32'h0);
    chk("reset_ready", {31'd0, ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_after_reset", {31'd0, ready}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].c);
      chk_int($sformatf("vec%0d_latency_ok", i), int'(lat >= 2 && lat <= 25), 1);
      if (i == 0) chk_int("vec0_latency_exact", lat, 16);
    end

    // Result and ready must hold between operations.
    repeat (12) @(posedge clk);
    #1;
    chk("hold_c", C, 32'h0000_0000);
    chk("hold_ready", {31'd0, ready}, 32'h1);

    // Start pulse while busy is ignored.
    pulse_start(32'h3F80_0000, 32'h4040_0000);
    repeat (5) @(posedge clk);
    #2;
    A = 32'h40C0_0000;
    B = 32'h4000_0000;
    start = 1'b1;
    #1 start = 1'b0;
    wait_ready(lat);
    chk_int("busy_completes", int'(lat > 0), 1);
    chk("busy_result", C, 32'h3EAA_AAAB);
    dropped = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (!ready) dropped++;
    end
    chk_int("busy_start_ignored", dropped, 0);
    chk("busy_result_held", C, 32'h3EAA_AAAB);

    // Reset during ITER clears outputs at once, then the block recovers.
    pulse_start(32'h40C0_0000, 32'h4000_0000);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_c", C, 32'h0);
    chk("midop_reset_ready", {31'd0, ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_resume_after_reset", {31'd0, ready}, 32'h0);
    do_op(32'h40C0_0000, 32'h4000_0000, res, lat);
    chk("recover_result", res, 32'h4040_0000);

    bad_lat = 0;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a, b;
      a   = rand_fp();
      b   = rand_fp();
      exp = ref_div(a, b);
      do_op(a, b, res, lat);
      if (lat < 2 || lat > 25) bad_lat++;
      chk($sformatf("rand%0d a=%h b=%h", i, a, b), res, exp);
    end
    chk_int("rand_latency_violations", bad_lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
